easy_serial_in: RTL and testbench

Serial receiver stage that sits directly downstream of the alarm module's serial transmitter. It decodes the `SEND`/`SDATA` frame pair back into a parallel message. A new value is published only after it has arrived in `CONFIRM` consecutive identical frames. The block also flags malformed frames and declares the link lost when no good frame arrives for `TIMEOUT` cycles.

---
 rtl/easy_serial_in.sv | 214 +++++++++++++++++++++
 tb/tb_easy_serial_in.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/easy_serial_in.sv
// easy_serial_in: receives SEND/SDATA frames (LSB first) from the alarm
// transmitter and publishes a message once it has been seen in CONFIRM
// consecutive identical good frames. Malformed frames pulse frame_err, and
// link_lost is held while no good frame has arrived for TIMEOUT cycles.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for the first SEND-high edge of a frame
// S_RECV  | shifting in bits; the first SEND-low edge decides the frame
// S_DRAIN | overlong frame already flagged, waiting for SEND to drop
module easy_serial_in #(
  parameter int WIDTH   = 4,
  parameter int CONFIRM = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             SEND,
  input  logic             SDATA,
  output logic [WIDTH-1:0] msg,
  output logic             msg_valid,
  output logic             frame_err,
  output logic             link_lost
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(CONFIRM + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);
  localparam logic [MW-1:0] CONF_MAX  = MW'(CONFIRM);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] shreg_ins;

  logic [WIDTH-1:0] cand;
  logic [MW-1:0]    match_cnt;
  logic [MW-1:0]    match_inc;
  logic             same_cand;
  logic             reached;
  logic             publish;
  logic             have_msg;

  // Set when the link is lost and held until the next publication, so that a
  // value re-confirmed after a loss is always announced again, even though
  // link_lost itself is already cleared by the first good frame.
  logic             relink;

  logic [TW-1:0]    tmo_cnt;
  logic             loss_evt;

  logic             start_frame;
  logic             store_bit;
  logic             good_frame;
  logic             err_frame;

  // FSM state register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state decision from SEND and the bit count
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (SEND) state_nxt = S_RECV;
      end
      S_RECV: begin
        if (SEND && (bit_cnt == CNT_FULL)) state_nxt = S_DRAIN;
        else if (!SEND)                    state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (!SEND) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: per-edge frame events consumed by the datapath
  always_comb begin
    start_frame = 1'b0;
    store_bit   = 1'b0;
    good_frame  = 1'b0;
    err_frame   = 1'b0;
    case (state)
      S_IDLE: begin
        start_frame = SEND;
      end
      S_RECV: begin
        if (SEND) begin
          if (bit_cnt == CNT_FULL) err_frame = 1'b1;
          else                     store_bit = 1'b1;
        end else begin
          if (bit_cnt == CNT_FULL) good_frame = 1'b1;
          else                     err_frame  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Next shift-register contents for the first bit and for a later bit
  always_comb begin
    first_word    = '0;
    first_word[0] = SDATA;
    shreg_ins     = shreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (bit_cnt == CW'(i)) shreg_ins[i] = SDATA;
    end
  end

  // Bit counter and shift register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (start_frame) begin
      bit_cnt <= CW'(1);
      shreg   <= first_word;
    end else if (store_bit) begin
      bit_cnt <= bit_cnt + CW'(1);
      shreg   <= shreg_ins;
    end else if (good_frame || err_frame) begin
      bit_cnt <= '0;
    end
  end

  // Confirm decision for the frame held in shreg at the decision edge.
  // "Reached" means the count arrives at CONFIRM on this frame, not that it
  // was already saturated there by earlier identical frames.
  always_comb begin
    same_cand = (shreg == cand) && (match_cnt != '0);
    if (same_cand) begin
      match_inc = (match_cnt == CONF_MAX) ? match_cnt : match_cnt + MW'(1);
    end else begin
      match_inc = MW'(1);
    end
    reached = good_frame && (match_inc == CONF_MAX) &&
              !(same_cand && (match_cnt == CONF_MAX));
    publish = reached &&
              ((shreg != msg) || !have_msg || link_lost || relink);
  end

  // Candidate and match count; an error frame or a link loss restarts
  // the confirmation sequence
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cand      <= '0;
      match_cnt <= '0;
    end else if (err_frame || loss_evt) begin
      match_cnt <= '0;
    end else if (good_frame) begin
      cand      <= shreg;
      match_cnt <= match_inc;
    end
  end

  // Published message, strobes and the published-state flags
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      msg       <= '0;
      msg_valid <= 1'b0;
      frame_err <= 1'b0;
      have_msg  <= 1'b0;
      relink    <= 1'b0;
    end else begin
      msg_valid <= publish;
      frame_err <= err_frame;
      if (publish) begin
        msg    <= shreg;
        relink <= 1'b0;
      end else if (loss_evt) begin
        relink <= 1'b1;
      end
      if (reached) have_msg <= 1'b1;
    end
  end

  // Loss is the single edge where the idle count steps onto TIMEOUT
  assign loss_evt = !good_frame && (tmo_cnt == TMO_LAST);

  // Cycles since the last good frame, and the link_lost level
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      tmo_cnt   <= '0;
      link_lost <= 1'b0;
    end else if (good_frame) begin
      tmo_cnt   <= '0;
      link_lost <= 1'b0;
    end else begin
      if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TW'(1);
      if (loss_evt)           link_lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_easy_serial_in.sv
// Bench for easy_serial_in: directed scenarios followed by random frames,
// every cycle compared against a frame-level reference model.
module tb_easy_serial_in;

  localparam int WIDTH   = 4;
  localparam int CONFIRM = 2;
  localparam int TIMEOUT = 64;

  logic             CLK;
  logic             RST_n;
  logic             SEND;
  logic             SDATA;
  logic [WIDTH-1:0] msg;
  logic             msg_valid;
  logic             frame_err;
  logic             link_lost;

  int n_vec;
  int n_err;

  // reference model state
  int run;
  int bits [WIDTH];
  int age;
  int streak;
  int cand;
  int m_msg;
  bit have;
  bit relink;
  bit m_valid;
  bit m_err;
  bit m_lost;

  easy_serial_in #(
    .WIDTH  (WIDTH),
    .CONFIRM(CONFIRM),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .SEND     (SEND),
    .SDATA    (SDATA),
    .msg      (msg),
    .msg_valid(msg_valid),
    .frame_err(frame_err),
    .link_lost(link_lost)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    run = 0; age = 0; streak = 0; cand = 0; m_msg = 0;
    have = 0; relink = 0; m_valid = 0; m_err = 0; m_lost = 0;
    for (int i = 0; i < WIDTH; i++) bits[i] = 0;
  endtask

  // One clock edge of the receiver, described by the length of the current
  // SEND-high run rather than by any state machine.
  task automatic model_step(input logic s, input logic d);
    bit good;
    bit newc;
    bit reached;
    int val;
    int prev;
    good = 0; newc = 0; reached = 0;
    m_valid = 0;
    m_err   = 0;
    if (s) begin
      run++;
      if (run <= WIDTH) bits[run-1] = int'(d);
      if (run == WIDTH + 1) begin
        m_err  = 1;
        streak = 0;
      end
    end else begin
      if (run == WIDTH) good = 1;
      else if (run > 0 && run < WIDTH) begin
        m_err  = 1;
        streak = 0;
      end
      run = 0;
    end
    if (good) begin
      val = 0;
      for (int i = 0; i < WIDTH; i++) val += bits[i] << i;
      prev = streak;
      if (val == cand && streak > 0) begin
        if (streak < CONFIRM) streak++;
      end else begin
        newc   = 1;
        cand   = val;
        streak = 1;
      end
      reached = (streak == CONFIRM) && (newc || prev < CONFIRM);
      if (reached && (cand != m_msg || !have || relink)) begin
        m_msg   = cand;
        m_valid = 1;
        have    = 1;
        relink  = 0;
      end
      age    = 0;
      m_lost = 0;
    end else if (age < TIMEOUT) begin
      age++;
      if (age == TIMEOUT) begin
        m_lost = 1;
        relink = 1;
        streak = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("msg",       32'(msg),       32'(m_msg));
    check("msg_valid", 32'(msg_valid), 32'(m_valid));
    check("frame_err", 32'(frame_err), 32'(m_err));
    check("link_lost", 32'(link_lost), 32'(m_lost));
    check("valid_err_excl", 32'(msg_valid & frame_err), 32'd0);
  endtask

  // Drive one cycle (called just after a falling edge), then check outputs
  // on the following falling edge.
  task automatic cycle(input logic s, input logic d);
    SEND  = s;
    SDATA = d;
    @(posedge CLK);
    model_step(s, d);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom));
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] val, input int len);
    for (int i = 0; i < len; i++) begin
      if (i < WIDTH) cycle(1'b1, val[i]);
      else           cycle(1'b1, 1'($urandom));
    end
  endtask

  task automatic do_reset();
    SEND  = 1'b0;
    RST_n = 1'b0;
    #1;
    model_reset();
    check("rst_msg",       32'(msg),       32'd0);
    check("rst_msg_valid", 32'(msg_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_link_lost", 32'(link_lost), 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
  endtask

  initial begin
    int len;
    int r;
    logic [WIDTH-1:0] val;
    n_vec = 0;
    n_err = 0;
    SEND  = 1'b0;
    SDATA = 1'b0;
    RST_n = 1'b0;
    model_reset();
    #2;
    check("rst_msg",       32'(msg),       32'd0);
    check("rst_msg_valid", 32'(msg_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_link_lost", 32'(link_lost), 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    idle(3);

    // confirmed value, then a repeat with no pulse
    send_frame(4'hA, WIDTH); idle(3);
    send_frame(4'hA, WIDTH); idle(1);
    check("confirm_A_msg", 32'(msg), 32'hA);
    idle(2);
    send_frame(4'hA, WIDTH); idle(1);
    check("repeat_A_no_pulse", 32'(msg_valid), 32'd0);
    idle(2);

    // candidate replacement
    send_frame(4'h3, WIDTH); idle(2);
    send_frame(4'h5, WIDTH); idle(2);
    send_frame(4'h5, WIDTH); idle(1);
    check("replace_5_pulse", 32'(msg_valid), 32'd1);
    idle(2);

    // short frame, then a fresh confirmation
    send_frame(4'h0, 3); idle(1);
    check("short_err", 32'(frame_err), 32'd1);
    idle(2);
    send_frame(4'h7, WIDTH); idle(2);
    send_frame(4'h7, WIDTH); idle(2);

    // overlong frame, then proof the receiver is back in idle
    send_frame(4'hF, WIDTH + 2); idle(3);
    send_frame(4'h1, WIDTH); idle(2);
    send_frame(4'h1, WIDTH); idle(2);

    // link loss and recovery
    send_frame(4'hC, WIDTH); idle(2);
    send_frame(4'hC, WIDTH); idle(TIMEOUT);
    check("link_not_yet", 32'(link_lost), 32'd0);
    idle(1);
    check("link_set", 32'(link_lost), 32'd1);
    idle(3);
    send_frame(4'hC, WIDTH); idle(1);
    check("link_clear", 32'(link_lost), 32'd0);
    idle(2);
    send_frame(4'hC, WIDTH); idle(1);
    check("relink_pulse", 32'(msg_valid), 32'd1);
    idle(2);

    // reset in the middle of a frame
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    do_reset();
    idle(2);
    send_frame(4'h9, WIDTH); idle(2);
    send_frame(4'h9, WIDTH); idle(1);
    check("after_rst_msg", 32'(msg), 32'h9);
    idle(2);

    // random traffic from a small value pool so repeats are frequent
    for (int k = 0; k < 250; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       len = WIDTH;
      else if (r == 7) len = int'($urandom_range(1, WIDTH - 1));
      else             len = int'($urandom_range(WIDTH + 1, WIDTH + 3));
      case ($urandom_range(0, 4))
        0:       val = 4'hA;
        1:       val = 4'h5;
        2:       val = 4'h3;
        3:       val = 4'hC;
        default: val = WIDTH'($urandom);
      endcase
      if ($urandom_range(0, 39) == 0) begin
        cycle(1'b1, val[0]);
        do_reset();
      end else begin
        send_frame(val, len);
      end
      if ($urandom_range(0, 19) == 0) idle(TIMEOUT + 6);
      else                            idle(int'($urandom_range(1, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
